// File: rtl/decoder_rr_arbiter_if.sv
// rtl/decoder_rr_arbiter_if.sv - request/grant bundle between requesters and the decoder arbiter
interface decoder_rr_arbiter_if;
  logic [31:0] req;
  logic        done;
  logic        A;
  logic        B;
  logic        C;
  logic        D;
  logic        E;
  logic        enable;
  logic [31:0] grant;
  logic        timeout;

  modport master (
    output req,
    output done,
    input  A,
    input  B,
    input  C,
    input  D,
    input  E,
    input  enable,
    input  grant,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output A,
    output B,
    output C,
    output D,
    output E,
    output enable,
    output grant,
    output timeout
  );
endinterface

// File: rtl/decoder_rr_arbiter.sv
// rtl/decoder_rr_arbiter.sv - round-robin arbiter driving the 5-to-32 decoder select and enable
module decoder_rr_arbiter #(
  parameter int MAX_HOLD = 15,
  parameter int HOLD_W   = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  decoder_rr_arbiter_if.slave  bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam bit              HOLD_EN    = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

  logic [0:0]        state;
  logic [4:0]        last;
  logic [HOLD_W-1:0] hold_cnt;
  logic              enable_q;
  logic              timeout_q;
  logic [31:0]       grant_q;

  logic              found;
  logic [4:0]        pick;
  logic [4:0]        cand;
  logic              release_now;
  logic              limit_hit;

  // Search starts just after the previous owner; offset 32 wraps back onto
  // the previous owner itself so it is considered last.
  always_comb begin
    found = 1'b0;
    pick  = last;
    cand  = '0;
    for (int k = 1; k <= 32; k++) begin
      cand = last + 5'(k);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign release_now = bus.done || !bus.req[last];
  assign limit_hit   = HOLD_EN && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      last      <= 5'd31;
      hold_cnt  <= '0;
      enable_q  <= 1'b0;
      timeout_q <= 1'b0;
      grant_q   <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            state    <= ST_GRANT;
            last     <= pick;
            hold_cnt <= '0;
            enable_q <= 1'b1;
            grant_q  <= 32'd1 << pick;
          end
        end
        ST_GRANT: begin
          // Owner release takes precedence over the hold limit.
          if (release_now) begin
            state    <= ST_IDLE;
            enable_q <= 1'b0;
            grant_q  <= '0;
          end else if (limit_hit) begin
            state     <= ST_IDLE;
            enable_q  <= 1'b0;
            grant_q   <= '0;
            timeout_q <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          enable_q <= 1'b0;
          grant_q  <= '0;
        end
      endcase
    end
  end

  assign {bus.A, bus.B, bus.C, bus.D, bus.E} = last;
  assign bus.enable  = enable_q;
  assign bus.grant   = grant_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// tb/tb_decoder_rr_arbiter.sv - self-checking bench for decoder_rr_arbiter
module tb_decoder_rr_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  decoder_rr_arbiter_if bus ();

  decoder_rr_arbiter #(.MAX_HOLD(15), .HOLD_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [4:0] sel;
  assign sel = {bus.A, bus.B, bus.C, bus.D, bus.E};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] req;
    logic        done;
    logic        en;
    logic [4:0]  sel;
    logic [31:0] grant;
    logic        to;
  } vec_t;

  vec_t vecs[13];
  int   exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.done = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(logic [31:0] r, logic d, logic e, logic [4:0] s, logic t);
    vec_t v;
    v.req   = r;
    v.done  = d;
    v.en    = e;
    v.sel   = s;
    v.grant = e ? (32'd1 << s) : 32'd0;
    v.to    = t;
    return v;
  endfunction

  initial begin
    int held;
    int exp_idx;
    checks   = 0;
    failures = 0;

    vecs[0]  = mk(32'h0000_0000, 1'b0, 1'b0, 5'd31, 1'b0);
    vecs[1]  = mk(32'h0000_0001, 1'b0, 1'b1, 5'd0,  1'b0);
    vecs[2]  = mk(32'h0000_0001, 1'b1, 1'b0, 5'd0,  1'b0);
    vecs[3]  = mk(32'h0000_0000, 1'b0, 1'b0, 5'd0,  1'b0);
    vecs[4]  = mk(32'h0000_0020, 1'b0, 1'b1, 5'd5,  1'b0);
    vecs[5]  = mk(32'h0000_0020, 1'b1, 1'b0, 5'd5,  1'b0);
    vecs[6]  = mk(32'h0010_0008, 1'b0, 1'b1, 5'd20, 1'b0);
    vecs[7]  = mk(32'h0010_0008, 1'b1, 1'b0, 5'd20, 1'b0);
    vecs[8]  = mk(32'h0010_0008, 1'b0, 1'b1, 5'd3,  1'b0);
    vecs[9]  = mk(32'h0010_000A, 1'b0, 1'b1, 5'd3,  1'b0);
    vecs[10] = mk(32'h0000_0002, 1'b0, 1'b0, 5'd3,  1'b0);
    vecs[11] = mk(32'h0000_0002, 1'b1, 1'b1, 5'd1,  1'b0);
    vecs[12] = mk(32'h0000_0000, 1'b0, 1'b0, 5'd1,  1'b0);

    do_reset();
    check("rst_enable", 32'(bus.enable), 32'd0);
    check("rst_grant", bus.grant, 32'd0);
    check("rst_timeout", 32'(bus.timeout), 32'd0);
    check("rst_sel", 32'(sel), 32'd31);

    for (int i = 0; i < 13; i++) begin
      bus.req  = vecs[i].req;
      bus.done = vecs[i].done;
      tick();
      check($sformatf("vec%0d_enable", i), 32'(bus.enable), 32'(vecs[i].en));
      check($sformatf("vec%0d_sel", i), 32'(sel), 32'(vecs[i].sel));
      check($sformatf("vec%0d_grant", i), bus.grant, vecs[i].grant);
      check($sformatf("vec%0d_timeout", i), 32'(bus.timeout), 32'(vecs[i].to));
    end
    bus.done = 1'b0;

    // Full-load sweep: expected owners queued up front, popped per grant.
    do_reset();
    bus.req = 32'hFFFF_FFFF;
    for (int i = 0; i < 32; i++) exp_q.push_back(i);
    exp_q.push_back(0);
    while (exp_q.size() > 0) begin
      exp_idx = exp_q.pop_front();
      tick();
      check("sweep_enable", 32'(bus.enable), 32'd1);
      check("sweep_sel", 32'(sel), 32'(exp_idx));
      check("sweep_grant", bus.grant, 32'd1 << exp_idx);
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      check("sweep_gap", 32'(bus.enable), 32'd0);
    end
    bus.req = '0;

    // Hold limit on index 7 with index 9 waiting.
    do_reset();
    bus.req = 32'h0000_0280;
    held = 0;
    tick();
    for (int w = 0; w < 20 && bus.enable && sel == 5'd7; w++) begin
      held++;
      check("hold_no_timeout", 32'(bus.timeout), 32'd0);
      tick();
    end
    check("hold_cycles", 32'(held), 32'd15);
    check("hold_timeout_pulse", 32'(bus.timeout), 32'd1);
    check("hold_timeout_enable", 32'(bus.enable), 32'd0);
    check("hold_timeout_grant", bus.grant, 32'd0);
    tick();
    check("hold_pulse_width", 32'(bus.timeout), 32'd0);
    check("hold_next_enable", 32'(bus.enable), 32'd1);
    check("hold_next_sel", 32'(sel), 32'd9);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req  = '0;

    // Done coinciding with the hold-limit cycle.
    do_reset();
    bus.req = 32'h0000_0010;
    tick();
    check("limit_done_grant", 32'(sel), 32'd4);
    for (int k = 0; k < 14; k++) tick();
    check("limit_done_still_held", 32'(bus.enable), 32'd1);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    check("limit_done_enable", 32'(bus.enable), 32'd0);
    check("limit_done_timeout", 32'(bus.timeout), 32'd0);
    bus.req = '0;
    tick();
    check("limit_done_after", 32'(bus.timeout), 32'd0);

    // Asynchronous reset mid-grant at index 12.
    do_reset();
    bus.req = 32'h0000_1000;
    tick();
    check("arst_pre_sel", 32'(sel), 32'd12);
    check("arst_pre_enable", 32'(bus.enable), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_enable", 32'(bus.enable), 32'd0);
    check("arst_grant", bus.grant, 32'd0);
    check("arst_timeout", 32'(bus.timeout), 32'd0);
    check("arst_sel", 32'(sel), 32'd31);
    tick();
    bus.req = 32'h0000_1001;
    rst_n   = 1'b1;
    tick();
    check("arst_first_sel", 32'(sel), 32'd0);
    check("arst_first_grant", bus.grant, 32'h0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decoder_rr_arbiter.md
# decoder_rr_arbiter

Round-robin arbiter that shares the 5-to-32 decoder among 32 requesters. Each cycle it selects at most one requester and drives the decoder's select bits A..E and `enable`. A registered one-hot `grant` vector mirrors the decoder output for checking. It holds a grant until the owner signals `done`, drops its request, or exceeds a hold limit.

## Interface
- `MAX_HOLD`, default 15: maximum cycles a grant may be held; 0 disables the timeout.
- `HOLD_W`, default 4: width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  32  request vector; `req[i]` is high while requester i wants the decoder.
- `done`  in  1  the current owner releases the grant; ignored when no grant is active.
- `A`,`B`,`C`,`D`,`E`  out  1 each  decoder select index, A = MSB (bit 4), E = LSB (bit 0).
- `enable`  out  1  decoder enable; high exactly while a grant is active.
- `grant`  out  32  registered one-hot, equals `1 << {A,B,C,D,E}` when `enable`=1, else 0.
- `timeout`  out  1  one-cycle pulse when a grant is force-released by the hold limit.

## Operation
- States: IDLE and GRANT.
- Reset (async, immediate) values:
  - state=IDLE, `enable`=0, `grant`=0, `timeout`=0.
  - {A..E}=5'd31; the pointer `last`=31, so the first search starts at index 0.
  - hold_cnt=0.
- IDLE:
  - If `req`≠0, pick the first set `req[i]` searching from `last+1` upward, wrapping mod 32.
  - Next cycle: GRANT, {A..E}=i, `enable`=1, `grant`=1<<i, `last`=i, hold_cnt=0.
  - If `req`=0, stay in IDLE; all outputs unchanged except `enable`/`grant` stay 0.
- GRANT, evaluated each cycle against the current owner idx:
  - `done`=1, or `req[idx]`=0: release. Next cycle IDLE, `enable`=0, `grant`=0; no timeout pulse.
  - Else if MAX_HOLD≠0 and hold_cnt==MAX_HOLD-1: forced release. Next cycle IDLE, `enable`=0, `grant`=0, `timeout`=1 for that one cycle.
  - Else hold_cnt increments and the grant is held.
- `done` and the hold limit in the same cycle: the normal release wins; `timeout` stays 0.
- {A..E} holds the last granted index while idle and changes only on a new grant. Select bits never change while `enable`=1.
- Fairness: the granted index has lowest priority in the next arbitration. With all 32 requesting continuously, grants run 0,1,…,31,0,…
- A requester that is force-released keeps its place only through the pointer; it is not re-granted before other pending requesters.
- `req` changes for non-owners during GRANT have no effect until the next arbitration.

## Timing
- Arbitration latency: `req` sampled at edge t gives `enable`/`grant` valid after edge t+1 (one cycle from IDLE).
- Release takes effect one edge after `done` is sampled high.
- IDLE always lasts at least one cycle between consecutive grants (one-cycle gap, `enable`=0).
- Maximum grant duration is MAX_HOLD cycles of `enable`=1. Back-to-back throughput is one grant per 2 cycles minimum.
- All outputs are registered; no combinational path from `req`/`done` to outputs.
- Reset asserted mid-grant: `enable`, `grant` and `timeout` go to 0 asynchronously; the pointer returns to 31.

## Test plan
- After reset, `req`=32'h0000_0001: next cycle {A..E}=0, `enable`=1, `grant`=32'h1. Then `done`=1 for one cycle: next cycle `enable`=0, `grant`=0.
- `req`=32'hFFFF_FFFF held, `done` pulsed in each grant's first cycle: granted indices are 0,1,2,…,31,0 with one idle cycle between each.
- `last`=5 and `req` bits 3 and 20 set: grant goes to 20, then 3 (wrap-around).
- `req[7]` held, `done`=0, MAX_HOLD=15: `enable` high for exactly 15 cycles, then `timeout`=1 for one cycle with `enable`=0. The next grant follows if other requests are pending.
- `done`=1 on the hold-limit cycle: release occurs and `timeout` stays 0. Separately, dropping `req[idx]` mid-grant releases on the next edge with no timeout.
- `rst_n` pulsed low mid-grant at index 12: outputs clear immediately. After release of reset with `req` bits 12 and 0 set, index 0 is granted first.
